// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared constants and lane arithmetic for the 2x2 pooling stream
package pool_pkg;

  localparam logic [1:0] POOL_BYPASS = 2'b00;
  localparam logic [1:0] POOL_MAX    = 2'b01;
  localparam logic [1:0] POOL_AVG    = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TOP  = 2'd1;
  localparam logic [1:0] ST_BOT  = 2'd2;
  localparam logic [1:0] ST_PASS = 2'd3;

  // Lanes are widened to LANE_PW bits so one signed compare/sum serves both signednesses.
  localparam int LANE_PW = 34;

  function automatic logic [LANE_PW-1:0] lane_ext(input logic [LANE_PW-1:0] x, input int w,
                                                  input logic sgn);
    logic [LANE_PW-1:0] t;
    t = x << (LANE_PW - w);
    if (sgn) t = $signed(t) >>> (LANE_PW - w);
    else     t = t >> (LANE_PW - w);
    return t;
  endfunction

  function automatic logic [LANE_PW-1:0] lane_max(input logic [LANE_PW-1:0] a,
                                                  input logic [LANE_PW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [LANE_PW-1:0] lane_avg4(input logic [LANE_PW-1:0] a,
                                                   input logic [LANE_PW-1:0] b,
                                                   input logic [LANE_PW-1:0] c,
                                                   input logic [LANE_PW-1:0] d);
    logic [LANE_PW-1:0] s;
    s = a + b + c + d + LANE_PW'(2);
    return $signed(s) >>> 2;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - half-row store of horizontal partials; sync write, async read
module pool_line_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int WIDTH = 54
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pool2x2_stream.sv
// rtl/pool2x2_stream.sv - 2x2 stride-2 max/avg pooling over a row-major pixel stream
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DN    = 6,
  parameter int MAX_W = 64,
  parameter int HW    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [$clog2(MAX_W):0] i_cfg_width,
  input  logic [HW-1:0]         i_cfg_height,
  input  logic [1:0]            i_cfg_mode,
  input  logic                  i_cfg_signed,
  output logic                  o_cfg_err,
  input  logic [DN*DW-1:0]      i_m_data,
  input  logic                  i_m_valid,
  output logic                  o_m_ready,
  output logic [DN*DW-1:0]      o_s_data,
  output logic                  o_s_valid,
  input  logic                  i_s_ready,
  output logic                  o_s_last,
  output logic                  o_busy
);

  localparam int CW    = $clog2(MAX_W) + 1;
  localparam int DEPTH = MAX_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW    = DN * (DW + 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_col;
  logic [HW-1:0]    r_row;
  logic [CW-1:0]    r_w;
  logic [HW-1:0]    r_h;
  logic [1:0]       r_mode;
  logic             r_sgn;
  logic [DN*DW-1:0] r_held;
  logic [DN*DW-1:0] r_s_data;
  logic             r_s_valid;
  logic             r_s_last;
  logic             r_cfg_err;

  logic             w_idle, w_legal, w_out_free, w_acc;
  logic [CW-1:0]    w_width;
  logic [HW-1:0]    w_height;
  logic [1:0]       w_mode;
  logic             w_sgn;
  logic             w_last_col, w_eof, w_last_win;
  logic [1:0]       w_cur, w_next;
  logic             w_emit, w_lb_we;
  logic [LW-1:0]    w_lb_wdata, w_lb_rdata;
  logic [DN*DW-1:0] w_pool_data;
  logic [LANE_PW-1:0] w_pe [DN];
  logic [LANE_PW-1:0] w_he [DN];
  logic [LANE_PW-1:0] w_ce [DN];

  assign w_idle     = (r_state == ST_IDLE);
  assign w_legal    = (i_cfg_width != '0) && (i_cfg_width <= CW'(MAX_W)) &&
                      (i_cfg_height != '0) && (i_cfg_mode != 2'b11);
  assign w_out_free = !r_s_valid || i_s_ready;
  assign o_m_ready  = w_idle ? (w_legal && w_out_free) : w_out_free;
  assign w_acc      = i_m_valid && o_m_ready;

  // In IDLE the beat being accepted is described by the live cfg inputs, not the latched copy.
  assign w_width  = w_idle ? i_cfg_width  : r_w;
  assign w_height = w_idle ? i_cfg_height : r_h;
  assign w_mode   = w_idle ? i_cfg_mode   : r_mode;
  assign w_sgn    = w_idle ? i_cfg_signed : r_sgn;

  assign w_last_col = (r_col == w_width - CW'(1));
  assign w_eof      = w_last_col && (r_row == w_height - HW'(1));
  assign w_last_win = (r_row == {r_h[HW-1:1], 1'b0} - HW'(1)) &&
                      (r_col == {r_w[CW-1:1], 1'b0} - CW'(1));

  always_comb begin
    w_cur = r_state;
    if (w_idle) w_cur = (i_cfg_mode == POOL_BYPASS) ? ST_PASS : ST_TOP;
    w_next = w_cur;
    if (w_eof) w_next = ST_IDLE;
    else if (w_last_col) begin
      if (w_cur == ST_TOP)      w_next = ST_BOT;
      else if (w_cur == ST_BOT) w_next = ST_TOP;
    end
  end

  assign w_emit  = w_acc && ((w_cur == ST_PASS) || ((w_cur == ST_BOT) && r_col[0]));
  assign w_lb_we = w_acc && (w_cur == ST_TOP) && r_col[0];

  // Partials are stored DW+1 wide: the pair max re-extended, or the exact pair sum.
  always_comb begin
    w_lb_wdata  = '0;
    w_pool_data = '0;
    for (int k = 0; k < DN; k++) begin
      w_ce[k] = lane_ext(LANE_PW'(i_m_data[k*DW +: DW]), DW, w_sgn);
      w_he[k] = lane_ext(LANE_PW'(r_held[k*DW +: DW]), DW, w_sgn);
      w_pe[k] = lane_ext(LANE_PW'(w_lb_rdata[k*(DW+1) +: (DW+1)]), DW + 1, w_sgn);
      w_lb_wdata[k*(DW+1) +: (DW+1)] = (w_mode == POOL_MAX) ?
          (DW+1)'(lane_max(w_he[k], w_ce[k])) : (DW+1)'(w_he[k] + w_ce[k]);
      w_pool_data[k*DW +: DW] = (w_mode == POOL_MAX) ?
          DW'(lane_max(lane_max(w_pe[k], w_he[k]), w_ce[k])) :
          DW'(lane_avg4(w_pe[k], '0, w_he[k], w_ce[k]));
    end
  end

  pool_line_buf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (LW)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_we    (w_lb_we),
    .i_waddr (r_col[AW:1]),
    .i_wdata (w_lb_wdata),
    .i_raddr (r_col[AW:1]),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_mode    <= POOL_BYPASS;
      r_sgn     <= 1'b0;
      r_held    <= '0;
      r_s_data  <= '0;
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_idle && !w_legal;
      if (w_acc) begin
        if (w_idle) begin
          r_w    <= i_cfg_width;
          r_h    <= i_cfg_height;
          r_mode <= i_cfg_mode;
          r_sgn  <= i_cfg_signed;
        end
        if (!r_col[0]) r_held <= i_m_data;
        r_state <= w_next;
        if (w_eof) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + HW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_emit) begin
        r_s_data  <= (w_cur == ST_PASS) ? i_m_data : w_pool_data;
        r_s_last  <= (w_cur == ST_PASS) ? w_eof : w_last_win;
        r_s_valid <= 1'b1;
      end else if (i_s_ready) begin
        r_s_valid <= 1'b0;
        r_s_last  <= 1'b0;
      end
    end
  end

  assign o_s_data  = r_s_data;
  assign o_s_valid = r_s_valid;
  assign o_s_last  = r_s_last;
  assign o_cfg_err = r_cfg_err;
  assign o_busy    = !w_idle || r_s_valid;

endmodule

// File: tb/tb_pool2x2_stream.sv
// tb/tb_pool2x2_stream.sv - randomized self-checking bench for pool2x2_stream
module tb_pool2x2_stream;

  localparam int DW = 8, DN = 6, MAX_W = 64, HW = 10, BW = DN * DW;

  logic          i_clk = 1'b0, i_rst = 1'b1;
  logic [6:0]    i_cfg_width = 7'd4;
  logic [HW-1:0] i_cfg_height = 10'd2;
  logic [1:0]    i_cfg_mode = 2'b01;
  logic          i_cfg_signed = 1'b0;
  logic          o_cfg_err;
  logic [BW-1:0] i_m_data = '0;
  logic          i_m_valid = 1'b0;
  logic          o_m_ready;
  logic [BW-1:0] o_s_data;
  logic          o_s_valid;
  logic          i_s_ready = 1'b1;
  logic          o_s_last;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  pool2x2_stream #(.DW(DW), .DN(DN), .MAX_W(MAX_W), .HW(HW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_width(i_cfg_width), .i_cfg_height(i_cfg_height),
    .i_cfg_mode(i_cfg_mode), .i_cfg_signed(i_cfg_signed), .o_cfg_err(o_cfg_err),
    .i_m_data(i_m_data), .i_m_valid(i_m_valid), .o_m_ready(o_m_ready),
    .o_s_data(o_s_data), .o_s_valid(o_s_valid), .i_s_ready(i_s_ready),
    .o_s_last(o_s_last), .o_busy(o_busy)
  );

  int n_tests = 0, n_fail = 0;
  logic [BW-1:0] frame_q[$], got_d[$], exp_d[$];
  logic          got_l[$], exp_l[$];
  int            hold_err, ready_err;
  bit            timed_out;

  function automatic int lane_val(input logic [BW-1:0] px, input int k, input bit sgn);
    logic [7:0] b;
    b = px[k*8 +: 8];
    return sgn ? int'($signed(b)) : int'(b);
  endfunction

  // Reference: each 2x2 window computed directly from frame coordinates.
  function automatic void build_model(input int w, input int h, input logic [1:0] mode, input bit sgn);
    exp_d.delete();
    exp_l.delete();
    if (mode == 2'b00) begin
      foreach (frame_q[i]) begin
        exp_d.push_back(frame_q[i]);
        exp_l.push_back(i == frame_q.size() - 1);
      end
    end else begin
      for (int wr = 0; wr < h / 2; wr++) begin
        for (int wc = 0; wc < w / 2; wc++) begin
          logic [BW-1:0] o;
          for (int k = 0; k < DN; k++) begin
            int v[4];
            int r;
            v[0] = lane_val(frame_q[(2*wr)*w + 2*wc], k, sgn);
            v[1] = lane_val(frame_q[(2*wr)*w + 2*wc + 1], k, sgn);
            v[2] = lane_val(frame_q[(2*wr+1)*w + 2*wc], k, sgn);
            v[3] = lane_val(frame_q[(2*wr+1)*w + 2*wc + 1], k, sgn);
            if (mode == 2'b01) begin
              r = v[0];
              for (int j = 1; j < 4; j++) if (v[j] > r) r = v[j];
            end else begin
              r = int'($floor((v[0] + v[1] + v[2] + v[3]) / 4.0 + 0.5));
            end
            o[k*8 +: 8] = r[7:0];
          end
          exp_d.push_back(o);
          exp_l.push_back((wr == h / 2 - 1) && (wc == w / 2 - 1));
        end
      end
    end
  endfunction

  task automatic run_frame(input int w, input int h, input logic [1:0] mode, input bit sgn,
                           input bit bp, input int stop_at);
    int idx = 0, burst = 0, n, limit;
    bit vld = 0, held = 0, done = 0, acc_now;
    logic [BW-1:0] pd;
    logic pl;
    n = frame_q.size();
    limit = (stop_at >= 0) ? stop_at : n;
    got_d.delete();
    got_l.delete();
    hold_err = 0;
    ready_err = 0;
    i_cfg_width = 7'(w);
    i_cfg_height = 10'(h);
    i_cfg_mode = mode;
    i_cfg_signed = sgn;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(posedge i_clk);
      #1;
      if (idx > 0) begin
        i_cfg_width = 7'($urandom_range(0, 127));
        i_cfg_height = 10'($urandom_range(0, 1023));
        i_cfg_mode = 2'($urandom_range(0, 3));
        i_cfg_signed = 1'($urandom_range(0, 1));
      end
      if (!vld && idx < limit) vld = ($urandom_range(0, 4) != 0);
      i_m_valid = vld;
      i_m_data = vld ? frame_q[idx] : BW'({$urandom(), $urandom()});
      if (!bp) i_s_ready = 1'b1;
      else if (burst > 0) begin i_s_ready = 1'b0; burst--; end
      else if ($urandom_range(0, 5) == 0) begin i_s_ready = 1'b0; burst = 4; end
      else i_s_ready = 1'b1;
      @(negedge i_clk);
      if (held && (o_s_data !== pd || o_s_last !== pl)) hold_err++;
      if (o_s_valid && !i_s_ready && o_m_ready) ready_err++;
      held = o_s_valid && !i_s_ready;
      pd = o_s_data;
      pl = o_s_last;
      if (o_s_valid && i_s_ready) begin
        got_d.push_back(o_s_data);
        got_l.push_back(o_s_last);
      end
      acc_now = i_m_valid && o_m_ready;
      if (acc_now) begin idx++; vld = 0; end
      if (stop_at >= 0) done = (idx == limit);
      else done = (idx == n) && !o_busy && !acc_now;
    end
    timed_out = !done;
    @(posedge i_clk);
    #1;
    i_m_valid = 1'b0;
    i_s_ready = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_tests++; if (o_s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid got %b exp 0", o_s_valid); end
    n_tests++; if (o_s_last !== 1'b0) begin n_fail++; $display("FAIL reset_s_last got %b exp 0", o_s_last); end
    n_tests++; if (o_s_data !== '0) begin n_fail++; $display("FAIL reset_s_data got %h exp 0", o_s_data); end
    n_tests++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b exp 0", o_cfg_err); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    i_rst = 1'b0;
  endtask

  task automatic test_cfg_err();
    @(posedge i_clk); #1;
    i_cfg_width = 7'd4; i_cfg_height = 10'd2; i_cfg_mode = 2'b11; i_m_valid = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_tests++; if (o_cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_mode got %b exp 1", o_cfg_err); end
    n_tests++; if (o_m_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_err_ready got %b exp 0", o_m_ready); end
    i_cfg_mode = 2'b01; i_cfg_width = 7'd65;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_tests++; if (o_cfg_err !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_width err %b busy %b exp 1 0", o_cfg_err, o_busy); end
    i_m_valid = 1'b0; i_cfg_width = 7'd64;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    n_tests++; if (o_cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear got %b exp 0", o_cfg_err); end
  endtask

  task automatic test_directed_pool(input string name, input logic [1:0] mode, input logic [7:0] e0,
                                    input logic [7:0] e1);
    logic [7:0] v[8] = '{8'd1, 8'd2, 8'd3, 8'd9, 8'd4, 8'd1, 8'd5, 8'd10};
    logic [BW-1:0] ed[2];
    logic el[2] = '{1'b0, 1'b1};
    ed[0] = {6{e0}};
    ed[1] = {6{e1}};
    frame_q.delete();
    foreach (v[i]) frame_q.push_back({6{v[i]}});
    run_frame(4, 2, mode, 1'b0, 1'b0, -1);
    n_tests++; if (timed_out || got_d.size() != 2) begin n_fail++; $display("FAIL %s_count got %0d exp 2 timeout %b", name, got_d.size(), timed_out); end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (i >= got_d.size() || got_d[i] !== ed[i] || got_l[i] !== el[i]) begin
        n_fail++;
        $display("FAIL %s_out%0d got %h/%b exp %h/%b", name, i,
                 (i < got_d.size()) ? got_d[i] : 'x, (i < got_l.size()) ? got_l[i] : 1'bx, ed[i], el[i]);
      end
    end
  endtask

  task automatic test_odd_frame();
    logic [7:0] v[9] = '{8'd6, 8'd4, 8'd1, 8'd5, 8'd4, 8'd1, 8'd1, 8'd2, 8'd3};
    frame_q.delete();
    foreach (v[i]) frame_q.push_back({6{v[i]}});
    run_frame(3, 3, 2'b01, 1'b0, 1'b0, -1);
    n_tests++;
    if (timed_out || got_d.size() != 1 || got_d[0] !== {6{8'h06}} || got_l[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_3x3 count %0d data %h last %b exp 1 %h 1", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 'x, (got_l.size() > 0) ? got_l[0] : 1'bx, {6{8'h06}});
    end
    @(negedge i_clk);
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL odd_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_signed();
    logic [7:0] a[4] = '{8'h80, 8'h01, 8'h02, 8'h03};
    logic [7:0] b[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
    logic [1:0] modes[3] = '{2'b01, 2'b01, 2'b10};
    bit sg[3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] ex[3] = '{8'h03, 8'h80, 8'hFF};
    for (int t = 0; t < 3; t++) begin
      frame_q.delete();
      for (int i = 0; i < 4; i++) frame_q.push_back({6{(t == 2) ? b[i] : a[i]}});
      run_frame(2, 2, modes[t], sg[t], 1'b0, -1);
      n_tests++;
      if (timed_out || got_d.size() != 1 || got_d[0] !== {6{ex[t]}} || got_l[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL signed_case%0d count %0d data %h exp %h", t, got_d.size(),
                 (got_d.size() > 0) ? got_d[0] : 'x, {6{ex[t]}});
      end
    end
  endtask

  task automatic test_backpressure();
    for (int it = 0; it < 2; it++) begin
      logic [1:0] mode;
      bit sgn;
      mode = (it == 0) ? 2'b01 : 2'b10;
      sgn = 1'($urandom_range(0, 1));
      frame_q.delete();
      for (int i = 0; i < 16; i++) frame_q.push_back(BW'({$urandom(), $urandom()}));
      build_model(4, 4, mode, sgn);
      run_frame(4, 4, mode, sgn, 1'b1, -1);
      n_tests++; if (timed_out || got_d.size() != 4) begin n_fail++; $display("FAIL bp%0d_count got %0d exp 4", it, got_d.size()); end
      n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL bp%0d_hold got %0d exp 0", it, hold_err); end
      n_tests++; if (ready_err != 0) begin n_fail++; $display("FAIL bp%0d_ready got %0d exp 0", it, ready_err); end
      for (int i = 0; i < exp_d.size(); i++) begin
        n_tests++;
        if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          n_fail++;
          $display("FAIL bp%0d_out%0d got %h exp %h/%b", it, i, (i < got_d.size()) ? got_d[i] : 'x, exp_d[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    int ws[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 64, 2, 5};
    for (int it = 0; it < 12; it++) begin
      int w, h;
      logic [1:0] mode;
      bit sgn, bp;
      w = ws[it];
      h = (w == 64) ? 2 : $urandom_range(1, 5);
      mode = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      sgn = 1'($urandom_range(0, 1));
      bp = 1'($urandom_range(0, 1));
      frame_q.delete();
      for (int i = 0; i < w * h; i++) frame_q.push_back(BW'({$urandom(), $urandom()}));
      build_model(w, h, mode, sgn);
      run_frame(w, h, mode, sgn, bp, -1);
      n_tests++;
      if (timed_out || got_d.size() != exp_d.size() || hold_err != 0 || ready_err != 0) begin
        n_fail++;
        $display("FAIL rand%0d_count w%0d h%0d got %0d exp %0d hold %0d ready %0d", it, w, h,
                 got_d.size(), exp_d.size(), hold_err, ready_err);
      end
      for (int i = 0; i < exp_d.size(); i++) begin
        n_tests++;
        if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
          n_fail++;
          $display("FAIL rand%0d_out%0d got %h exp %h/%b", it, i, (i < got_d.size()) ? got_d[i] : 'x, exp_d[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_bypass_reset();
    for (int ph = 0; ph < 3; ph++) begin
      frame_q.delete();
      for (int i = 0; i < 4; i++) frame_q.push_back(BW'({$urandom(), $urandom()}));
      build_model(2, 2, 2'b00, 1'b0);
      run_frame(2, 2, 2'b00, 1'b0, 1'b0, (ph == 1) ? 2 : -1);
      if (ph == 1) begin
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        n_tests++;
        if (o_s_valid !== 1'b0 || o_busy !== 1'b0 || o_s_last !== 1'b0) begin
          n_fail++;
          $display("FAIL byp_midreset valid %b busy %b last %b exp 0 0 0", o_s_valid, o_busy, o_s_last);
        end
        i_rst = 1'b0;
      end else begin
        n_tests++; if (timed_out || got_d.size() != 4) begin n_fail++; $display("FAIL byp%0d_count got %0d exp 4", ph, got_d.size()); end
        for (int i = 0; i < 4; i++) begin
          n_tests++;
          if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
            n_fail++;
            $display("FAIL byp%0d_out%0d got %h exp %h/%b", ph, i, (i < got_d.size()) ? got_d[i] : 'x, exp_d[i], exp_l[i]);
          end
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cfg_err();
    test_directed_pool("max_u", 2'b01, 8'h04, 8'h0A);
    test_directed_pool("avg_u", 2'b10, 8'h02, 8'h07);
    test_odd_frame();
    test_signed();
    test_backpressure();
    test_random_frames();
    test_bypass_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
